bvuge_bvmul_checker: RTL and testbench

BVUGE_BVMUL_CHECKER -- requirements
Module: bvuge_bvmul_checker

---
 rtl/bvc_pkg.sv | 17 +
 rtl/serial_mul.sv | 67 ++++++
 rtl/bvuge_bvmul_checker.sv | 113 +++++++++++
 tb/tb_bvuge_bvmul_checker.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/bvc_pkg.sv
// Shared definitions for the (a * x) >=u b constraint checker.
// Holds the controller state type and the default widths used by the
// checker top level and its serial multiplier.
package bvc_pkg;

    // Controller states: wait for a query, shift-add, compare, present verdict
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEFAULT_W     = 4;
    localparam int DEFAULT_CNT_W = 16;

endpackage

// File: rtl/serial_mul.sv
// Serial shift-add multiplier producing (a * x) mod 2^W.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   start      load a and x, clear the accumulator, begin a multiply
//   a, x       operands, sampled only while start is high
//   busy       high while bits of x are being consumed
//   done       one-cycle pulse after the last bit has been added
//   acc        running / final truncated product
module serial_mul
    import bvc_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] x,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] acc
);

    localparam int IDX_W = $clog2(W);

    logic [W-1:0]     a_reg;
    logic [W-1:0]     x_reg;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     addend;

    // Shifting left inside W bits drops the high partial-product bits,
    // which is exactly the mod 2^W truncation the product needs.
    always_comb begin
        addend = a_reg << idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            x_reg <= '0;
            idx   <= '0;
            acc   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_reg <= a;
                x_reg <= x;
                acc   <= '0;
                idx   <= '0;
                busy  <= 1'b1;
            end else if (busy) begin
                if (x_reg[idx]) begin
                    acc <= acc + addend;
                end
                if (idx == IDX_W'(W - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/bvuge_bvmul_checker.sv
// Checks a candidate witness x against the constraint ((a * x) mod 2^W) >=u b.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   in_valid, in_ready   query handshake (a, b, x sampled on accept)
//   a, b, x              multiplicand, bound and candidate witness
//   out_valid, out_ready verdict handshake
//   holds, prod          verdict and truncated product, stable while presented
//   pass_cnt, fail_cnt   saturating counts of accepted verdicts
module bvuge_bvmul_checker
    import bvc_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             holds,
    output logic [W-1:0]     prod,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    state_t       state;
    state_t       next_state;
    logic         accept;
    logic         release_verdict;
    logic         mul_busy;
    logic         mul_done;
    logic [W-1:0] mul_acc;
    logic [W-1:0] b_reg;

    assign accept          = in_valid & in_ready;
    assign release_verdict = out_valid & out_ready;

    serial_mul #(
        .W(W)
    ) u_mul (
        .clk  (clk),
        .rst  (rst),
        .start(accept),
        .a    (a),
        .x    (x),
        .busy (mul_busy),
        .done (mul_done),
        .acc  (mul_acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept)          next_state = MUL;
            MUL:  if (mul_done)        next_state = CMP;
            CMP:                       next_state = DONE;
            DONE: if (release_verdict) next_state = IDLE;
            default:                   next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) && !mul_busy;
        out_valid = (state == DONE);
    end

    // The bound is captured with the operands so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_reg <= '0;
        end else if (accept) begin
            b_reg <= b;
        end
    end

    // Verdict registers only change in CMP, so they stay frozen throughout DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            holds <= 1'b0;
            prod  <= '0;
        end else if (state == CMP) begin
            holds <= (mul_acc >= b_reg);
            prod  <= mul_acc;
        end
    end

    // Counters saturate at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (release_verdict) begin
            if (holds) begin
                if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
            end else begin
                if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bvuge_bvmul_checker.sv
// Self-checking bench for bvuge_bvmul_checker (W=4): directed queries,
// backpressure, mid-query reset and an exhaustive randomized-timing sweep
// against an arithmetic reference model.
module tb_bvuge_bvmul_checker;

    localparam int W     = 4;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [W-1:0]     x;
    logic             out_valid;
    logic             out_ready;
    logic             holds;
    logic [W-1:0]     prod;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;

    int checks;
    int errors;
    int exp_pass;
    int exp_fail;

    bvuge_bvmul_checker #(
        .W(W),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .x        (x),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .holds    (holds),
        .prod     (prod),
        .pass_cnt (pass_cnt),
        .fail_cnt (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic scrambleInputs();
        a = W'($urandom);
        b = W'($urandom);
        x = W'($urandom);
    endtask

    task automatic applyReset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_pass = 0;
        exp_fail = 0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_in_ready"}, int'(in_ready), 1);
        checkOutput({tag, "_out_valid"}, int'(out_valid), 0);
        checkOutput({tag, "_holds"}, int'(holds), 0);
        checkOutput({tag, "_prod"}, int'(prod), 0);
        checkOutput({tag, "_pass_cnt"}, int'(pass_cnt), 0);
        checkOutput({tag, "_fail_cnt"}, int'(fail_cnt), 0);
    endtask

    // One full query: offer, wait for the verdict, optionally stall, release.
    task automatic applyStimulus(input int av, input int bv, input int xv,
                                 input int stall, input bit chk_lat);
        int cyc;
        int exp_prod;
        int exp_holds;
        exp_prod  = (av * xv) % (1 << W);
        exp_holds = (exp_prod >= bv) ? 1 : 0;

        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("in_ready_idle", int'(in_ready), 1);

        in_valid = 1'b1;
        a = W'(av);
        b = W'(bv);
        x = W'(xv);
        @(posedge clk); #1;
        in_valid = 1'b0;
        scrambleInputs();

        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
            scrambleInputs();
        end
        if (chk_lat) checkOutput("latency", cyc, W + 2);
        checkOutput("out_valid", int'(out_valid), 1);
        checkOutput("holds", int'(holds), exp_holds);
        checkOutput("prod", int'(prod), exp_prod);

        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom);
            @(posedge clk); #1;
            checkOutput("stall_in_ready", int'(in_ready), 0);
            checkOutput("stall_out_valid", int'(out_valid), 1);
            checkOutput("stall_holds", int'(holds), exp_holds);
            checkOutput("stall_prod", int'(prod), exp_prod);
            checkOutput("stall_pass_cnt", int'(pass_cnt), exp_pass);
            checkOutput("stall_fail_cnt", int'(fail_cnt), exp_fail);
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (exp_holds == 1) exp_pass++;
        else                exp_fail++;
        checkOutput("released_out_valid", int'(out_valid), 0);
        checkOutput("pass_cnt", int'(pass_cnt), exp_pass);
        checkOutput("fail_cnt", int'(fail_cnt), exp_fail);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_pass  = 0;
        exp_fail  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        x = '0;

        applyReset();
        checkResetState("reset");

        $display("[TB] directed queries");
        applyStimulus(3, 9, 5, 0, 1'b1);
        applyStimulus(4, 1, 4, 0, 1'b1);
        applyStimulus(0, 0, 7, 0, 1'b0);
        applyStimulus(0, 2, 7, 0, 1'b0);

        $display("[TB] backpressure");
        applyStimulus(7, 5, 3, 10, 1'b1);

        $display("[TB] reset during MUL");
        while (!in_ready) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        a = 4'd5; b = 4'd3; x = 4'd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_pass = 0;
        exp_fail = 0;
        checkResetState("mid_reset");
        applyStimulus(5, 3, 6, 0, 1'b1);

        $display("[TB] exhaustive sweep");
        applyReset();
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int xi = 0; xi < 16; xi++) begin
                    applyStimulus(ai, bi, xi, int'($urandom_range(0, 2)), 1'b1);
                end
            end
        end
        checkOutput("sweep_total", int'(pass_cnt) + int'(fail_cnt), 4096);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
